// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder built from one full-adder slice
// (two half_adder cells plus an OR) that is reused once per clock.
// Operands are consumed LSB-first with a registered carry. The outputs
// only change when a complete result is available.

// half_adder: single-bit sum and carry of two inputs.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_A,
  input  logic [WIDTH-1:0] op_B,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  // Counter only ever has to reach WIDTH-1; on the last step it is cleared
  // instead of incremented, so it can never wrap mid-operation.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] sum_shift;
  logic             carry_ff;
  logic [CW-1:0]    count;

  logic ha0_s;
  logic ha0_c;
  logic slice_s;
  logic ha1_c;
  logic slice_c;
  logic last_step;

  // First half adder combines the two operand bits.
  half_adder u_ha0 (
    .a (shift_a[0]),
    .b (shift_b[0]),
    .s (ha0_s),
    .c (ha0_c)
  );

  // Second half adder folds in the registered carry.
  half_adder u_ha1 (
    .a (ha0_s),
    .b (carry_ff),
    .s (slice_s),
    .c (ha1_c)
  );

  assign slice_c   = ha0_c | ha1_c;
  assign last_step = (count == LAST_STEP);

  // FSM, datapath shift registers and result registers share one process
  // so the result, carry and overflow update on the same edge as DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_a   <= '0;
      shift_b   <= '0;
      sum_shift <= '0;
      carry_ff  <= 1'b0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ADD;
            shift_a  <= op_A;
            shift_b  <= op_B;
            carry_ff <= carry_in;
            count    <= '0;
            busy     <= 1'b1;
          end
        end
        ADD: begin
          sum_shift <= {slice_s, sum_shift[WIDTH-1:1]};
          shift_a   <= {1'b0, shift_a[WIDTH-1:1]};
          shift_b   <= {1'b0, shift_b[WIDTH-1:1]};
          carry_ff  <= slice_c;
          if (last_step) begin
            state     <= DONE;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            sum       <= {slice_s, sum_shift[WIDTH-1:1]};
            carry_out <= slice_c;
            overflow  <= carry_ff ^ slice_c;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that consumes the `half_adder` cell: two `half_adder` instances plus an OR form a single full-adder slice, reused once per clock under FSM control. It adds two WIDTH-bit operands LSB-first, one bit per cycle, with a registered carry. It sits directly downstream of the `half_adder` stage in the Laboratory 6 datapath and trades latency for area against the parallel adders.

## Interface
- `WIDTH`, 8, operand/result width in bits; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op_A`  in  WIDTH  first operand, captured on the accepting edge.
- `op_B`  in  WIDTH  second operand, captured on the accepting edge.
- `carry_in`  in  1  initial carry, captured on the accepting edge.
- `busy`  out  1  high while in ADD.
- `done`  out  1  one-cycle completion pulse.
- `sum`  out  WIDTH  registered result; held until the next completion.
- `carry_out`  out  1  final carry of the last result.
- `overflow`  out  1  signed overflow of the last result: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, ADD, DONE.
  - IDLE→ADD when `start`=1.
  - ADD→DONE after WIDTH bit-steps.
  - DONE→IDLE unconditionally.
- Accept (IDLE, `start`=1):
  - load shift_A←`op_A` and shift_B←`op_B`.
  - carry_ff←`carry_in`; bit counter←0.
- ADD cycle:
  - full-adder slice computes s, c from shift_A[0], shift_B[0] and carry_ff.
  - s shifts into the MSB of the internal sum shift register.
  - shift_A and shift_B shift right by 1; carry_ff←c; counter+1.
  - on the step where counter = WIDTH-1, also record the carry into the MSB (carry_ff before the update) for the overflow flag.
- Completion (last ADD step):
  - the output registers `sum`, `carry_out` and `overflow` load the final values at the same edge as the state changes to DONE.
  - Outputs never show partial results.
- Arithmetic: result = (`op_A` + `op_B` + `carry_in`) mod 2^WIDTH; `carry_out` = bit WIDTH of the full sum.
- `start` in ADD or DONE is ignored; no queueing. Operand changes after acceptance have no effect.
- Counter is sized to hold WIDTH-1 and never wraps during an operation.

## Timing
- Reset (asynchronous, `rst_n`=0): state=IDLE; `busy`, `done`, `sum`, `carry_out`, `overflow`, shift registers, carry_ff and counter all 0.
- Accept at edge k:
  - `busy`=1 from edge k through edge k+WIDTH.
  - last bit-step at edge k+WIDTH.
  - `done`=1 and valid outputs from edge k+WIDTH.
  - `done`=0 at edge k+WIDTH+1; state is IDLE.
- Latency: WIDTH cycles from the accepting edge to `done`. Maximum throughput is one operation per WIDTH+2 cycles (re-issue `start` in the cycle after `done`).
- `busy` and `done` are never high together.
- Reset asserted mid-ADD:
  - aborts the operation immediately; no `done` is issued.
  - outputs return to 0; the previous result is lost.
- Reset released: the first sampling of `start` occurs at the first rising edge with `rst_n`=1.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- WIDTH=8: `op_A`=0x00, `op_B`=0x00, `carry_in`=0, accepted at edge k → `busy` high for 8 cycles, `done`=1 exactly at edge k+8, `sum`=0x00, `carry_out`=0, `overflow`=0.
- 0xFF + 0x01, `carry_in`=0 → `sum`=0x00, `carry_out`=1, `overflow`=0.
- 0x7F + 0x01, `carry_in`=0 → `sum`=0x80, `carry_out`=0, `overflow`=1. Then 0x80 + 0x80 → `sum`=0x00, `carry_out`=1, `overflow`=1.
- 0xFF + 0xFF, `carry_in`=1 → `sum`=0xFF, `carry_out`=1.
  - Change `op_A` during ADD → result unchanged.
  - `start` pulses in ADD and DONE → ignored; exactly one `done`.
- Accept 0x12 + 0x34; pulse `rst_n` low at edge k+4 → all outputs 0, no `done`. Then 0x12 + 0x34 again → `sum`=0x46, `done` 8 cycles after acceptance.
- Back-to-back: 0xA5 + 0x5A, then `start` in the cycle after `done` with 0x01 + 0x02 → `sum`=0xFF, then 0x03. `sum` holds 0xFF until the second `done`.
